mem_wb_stage: RTL

//  MEM stage and MEM/WB pipeline register. Consumes the EX/MEM latch outputs and performs the

---
 rtl/mem_wb_stage.sv | 119 +++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM stage with multi-cycle internal data memory and the MEM/WB pipeline register.
// Stalls upstream while a load/store is in flight; branch decision is combinational.
module mem_wb_stage #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned MEM_LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_ctlin,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        zero,
  input  logic [31:0] add_result,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2,
  input  logic [4:0]  dest_reg,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        mem_stall,
  output logic        misalign,
  output logic [1:0]  wb_ctlout,
  output logic [31:0] read_data,
  output logic [31:0] alu_pass,
  output logic [4:0]  dest_out
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam int unsigned CW = $clog2(MEM_LAT) + 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   mem [MEM_DEPTH];

  logic [AW-1:0] idx;
  logic          req;
  logic          aligned;
  logic          access;
  logic          misreq;
  logic          complete;
  logic [31:0]   rd_word;

  assign idx           = alu_result[AW+1:2];
  assign rd_word       = mem[idx];
  assign pcsrc         = branch & zero;
  assign branch_target = add_result;

  always_comb begin
    req      = memread | memwrite;
    aligned  = (alu_result[1:0] == 2'b00);
    access   = req & aligned;
    misreq   = req & ~aligned;
    complete = 1'b0;
    if (MEM_LAT == 1) begin
      complete = access;
    end else begin
      complete = (state_q == StBusy) && (cnt_q == LAST);
    end
  end

  assign mem_stall = access & ~complete;

  // Write only on the completing edge; reset gating makes an aborted store a no-op.
  always_ff @(posedge clk) begin
    if (rst && complete && memwrite && aligned) begin
      mem[idx] <= rdata2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      misalign  <= 1'b0;
      wb_ctlout <= 2'b00;
      read_data <= '0;
      alu_pass  <= '0;
      dest_out  <= '0;
    end else begin
      misalign <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (misreq) begin
            misalign  <= 1'b1;
            wb_ctlout <= 2'b00;
          end else if (!access || complete) begin
            wb_ctlout <= wb_ctlin;
            alu_pass  <= alu_result;
            dest_out  <= dest_reg;
            read_data <= (access && memread) ? rd_word : 32'd0;
          end else begin
            state_q   <= StBusy;
            cnt_q     <= CW'(1);
            wb_ctlout <= 2'b00;
          end
        end
        StBusy: begin
          if (complete) begin
            // Non-blocking read gives the pre-write word for read+write requests.
            wb_ctlout <= wb_ctlin;
            alu_pass  <= alu_result;
            dest_out  <= dest_reg;
            read_data <= memread ? rd_word : 32'd0;
            state_q   <= StIdle;
            cnt_q     <= '0;
          end else begin
            cnt_q     <= cnt_q + CW'(1);
            wb_ctlout <= 2'b00;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
